// File: rtl/result_drain.sv
// result_drain: streams the systolic array's accumulated result matrix row-major as LANES-element
// beats on a valid/ready interface once a compute pass completes.
//
// Optional feature: define RESULT_DRAIN_HDR_EN to prefix every drain with a header beat carrying
// cycles_count (m_hdr=1, m_data[31:0]=cycles_count, upper bits 0).
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   compute_done    array done level (high from pass end until next array enable)
//   cycles_count    array cycle counter, valid with compute_done
//   output_matrix   element (i,j) at [(i*COLS+j)*OP_WIDTH +: OP_WIDTH]
//   flush           synchronous abort of an in-progress drain
//   drain_busy      high while streaming; array must keep en low
//   m_valid/m_ready beat handshake
//   m_data          lane k at [k*OP_WIDTH +: OP_WIDTH]
//   m_hdr, m_last   header beat / final beat flags
//   drain_done      one-cycle pulse after the last beat is accepted
//   err_overrun     sticky: a new done edge arrived while not idle
module result_drain #(
  parameter int unsigned ROWS     = 64,
  parameter int unsigned COLS     = 64,
  parameter int unsigned OP_WIDTH = 48,
  parameter int unsigned LANES    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         compute_done,
  input  logic [31:0]                  cycles_count,
  input  logic [ROWS*COLS*OP_WIDTH-1:0] output_matrix,
  input  logic                         flush,
  output logic                         drain_busy,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [LANES*OP_WIDTH-1:0]    m_data,
  output logic                         m_hdr,
  output logic                         m_last,
  output logic                         drain_done,
  output logic                         err_overrun
);

  localparam int unsigned NBeats = ROWS * COLS / LANES;
  localparam int unsigned BeatW  = LANES * OP_WIDTH;
  localparam int unsigned CntW   = (NBeats > 1) ? $clog2(NBeats) : 1;

  if ((COLS % LANES) != 0) begin : gen_lanes_check
    $error("result_drain: LANES must divide COLS");
  end

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e            state_q, state_d;
  logic              done_q;
  logic              armed_q;
  logic [CntW-1:0]   beat_q, beat_d;
  logic [BeatW-1:0]  data_q, data_d;
  logic              hdr_q, hdr_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              done_edge;

  // Row-major order makes beat b the contiguous slice of elements b*LANES .. b*LANES+LANES-1.
  logic [BeatW-1:0] beats [NBeats];
  for (genvar b = 0; b < NBeats; b++) begin : gen_beats
    assign beats[b] = output_matrix[b*BeatW +: BeatW];
  end

  // armed_q blocks a level-high compute_done seen right after reset from looking like a new pass;
  // a pass only counts once compute_done has been observed low.
  assign done_edge = compute_done & ~done_q & armed_q;

`ifndef RESULT_DRAIN_HDR_EN
  logic unused_cycles;
  assign unused_cycles = ^cycles_count;
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    hdr_d   = hdr_q;
    last_d  = last_q;
    err_d   = err_q;

    if (done_edge && (state_q != StIdle)) begin
      err_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (done_edge) begin
          state_d = StStream;
`ifdef RESULT_DRAIN_HDR_EN
          data_d        = '0;
          data_d[31:0]  = cycles_count;
          hdr_d         = 1'b1;
          last_d        = 1'b0;
`else
          data_d = beats[beat_q];
          hdr_d  = 1'b0;
          last_d = (beat_q == CntW'(NBeats - 1));
          beat_d = beat_q + 1'b1;
`endif
        end
      end
      StStream: begin
        // flush wins over a handshake in the same cycle
        if (flush) begin
          state_d = StIdle;
          beat_d  = '0;
          hdr_d   = 1'b0;
          last_d  = 1'b0;
        end else if (m_ready) begin
          if (last_q) begin
            state_d = StDone;
            beat_d  = '0;
            hdr_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            data_d = beats[beat_q];
            hdr_d  = 1'b0;
            last_d = (beat_q == CntW'(NBeats - 1));
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
      beat_q  <= '0;
      data_q  <= '0;
      hdr_q   <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= compute_done;
      if (!compute_done) begin
        armed_q <= 1'b1;
      end
      beat_q  <= beat_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign m_valid     = (state_q == StStream);
  assign drain_busy  = (state_q == StStream);
  assign drain_done  = (state_q == StDone);
  assign m_data      = data_q;
  assign m_hdr       = hdr_q;
  assign m_last      = last_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed testbench for result_drain (ROWS=2, COLS=4, LANES=2, OP_WIDTH=48,
// element (i,j) = 16*i+j). Expected beats are queued when a pass starts and
// popped as the DUT hands them over.
module tb_result_drain;
  localparam int ROWS  = 2;
  localparam int COLS  = 4;
  localparam int OPW   = 48;
  localparam int LANES = 2;
  localparam int NB    = ROWS * COLS / LANES;
  localparam int BW    = LANES * OPW;
`ifdef RESULT_DRAIN_HDR_EN
  localparam int NBT   = NB + 1;
`else
  localparam int NBT   = NB;
`endif

  logic                      clk;
  logic                      rst;
  logic                      compute_done;
  logic [31:0]               cycles_count;
  logic [ROWS*COLS*OPW-1:0]  output_matrix;
  logic                      flush;
  logic                      drain_busy;
  logic                      m_valid;
  logic                      m_ready;
  logic [BW-1:0]             m_data;
  logic                      m_hdr;
  logic                      m_last;
  logic                      drain_done;
  logic                      err_overrun;

  result_drain #(
    .ROWS(ROWS), .COLS(COLS), .OP_WIDTH(OPW), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .compute_done(compute_done), .cycles_count(cycles_count),
    .output_matrix(output_matrix), .flush(flush), .drain_busy(drain_busy),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_hdr(m_hdr),
    .m_last(m_last), .drain_done(drain_done), .err_overrun(err_overrun)
  );

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
    logic          hdr;
  } beat_t;

  beat_t exp_q[$];
  int    passed = 0;
  int    total  = 0;
  int    fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pass();
    beat_t e;
`ifdef RESULT_DRAIN_HDR_EN
    e.data = '0;
    e.data[31:0] = 32'h0000_01F4;
    e.last = 1'b0;
    e.hdr  = 1'b1;
    exp_q.push_back(e);
`endif
    for (int b = 0; b < NB; b++) begin
      e.data = '0;
      for (int k = 0; k < LANES; k++) begin
        int i;
        int j;
        i = b / (COLS / LANES);
        j = (b % (COLS / LANES)) * LANES + k;
        e.data[k*OPW +: OPW] = OPW'(16 * i + j);
      end
      e.last = (b == NB - 1);
      e.hdr  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // Raises compute_done and checks the one-cycle start latency; returns at the
  // negedge where the first beat is presented.
  task automatic start_pass();
    @(negedge clk);
    compute_done = 1'b1;
    m_ready = 1'b1;
    check("pre_start_valid", m_valid, 0);
    @(negedge clk);
    check("start_latency_valid", m_valid, 1);
    check("start_busy", drain_busy, 1);
    push_pass();
  endtask

  // Consumes queued beats; optionally stalls stall_len cycles on beat stall_at and,
  // with glitch set, pulses compute_done low then high during that stall.
  task automatic run_drain(input int stall_at, input int stall_len, input bit glitch,
                           output int cycles);
    int    popped = 0;
    int    left   = stall_len;
    beat_t e;
    cycles = 0;
    while (exp_q.size() > 0) begin
      if (cycles > 60) begin
        check("drain_timeout_beats_left", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
      cycles++;
      if (popped == stall_at && left > 0) begin
        m_ready = 1'b0;
        if (glitch && left == stall_len) compute_done = 1'b0;
        if (glitch && left == stall_len - 1) compute_done = 1'b1;
        left--;
      end else begin
        m_ready = 1'b1;
      end
      check("valid_until_done", m_valid, 1);
      if (!m_ready) begin
        check("stall_data_held", m_data, exp_q[0].data);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", m_data, e.data);
        check("beat_last", m_last, e.last);
        check("beat_hdr", m_hdr, e.hdr);
        check("beat_busy", drain_busy, 1);
        popped++;
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    check("done_pulse", drain_done, 1);
    check("done_busy_low", drain_busy, 0);
    check("done_valid_low", m_valid, 0);
    @(negedge clk);
    check("done_pulse_one_cycle", drain_done, 0);
  endtask

  task automatic idle_low(input int n);
    compute_done = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int    cyc;
    beat_t e;
    rst = 1'b1;
    compute_done = 1'b0;
    cycles_count = 32'h0000_01F4;
    flush = 1'b0;
    m_ready = 1'b1;
    output_matrix = '0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        output_matrix[(i*COLS+j)*OPW +: OPW] = OPW'(16 * i + j);
    #1 rst = 1'b0;
    #11;
    check("rst_valid", m_valid, 0);
    check("rst_busy", drain_busy, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_hdr", m_hdr, 0);
    check("rst_done", drain_done, 0);
    check("rst_err", err_overrun, 0);
    @(negedge clk);
    rst = 1'b1;

    // Full drain with m_ready held high: one beat per cycle.
    start_pass();
    run_drain(-1, 0, 1'b0, cyc);
    check("full_drain_cycles", cyc, NBT);
    // compute_done stays high: no retrigger
    repeat (4) @(negedge clk);
    check("level_no_retrigger_valid", m_valid, 0);
    check("level_no_retrigger_busy", drain_busy, 0);
    idle_low(2);

    // Backpressure on beat 1.
    start_pass();
    run_drain(1, 3, 1'b0, cyc);
    check("no_overrun_yet", err_overrun, 0);
    idle_low(2);

    // Overrun: done edge mid-drain; stream still completes.
    start_pass();
    run_drain(2, 3, 1'b1, cyc);
    check("overrun_set", err_overrun, 1);
    idle_low(2);
    check("overrun_sticky", err_overrun, 1);

    // Flush during beat 1 (flush beats the simultaneous handshake).
    start_pass();
    e = exp_q.pop_front();
    check("flush_beat0_data", m_data, e.data);
    @(negedge clk);
    check("flush_beat1_data", m_data, exp_q[0].data);
    flush = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    check("flush_valid_low", m_valid, 0);
    check("flush_busy_low", drain_busy, 0);
    check("flush_no_done", drain_done, 0);
    @(negedge clk);
    check("flush_no_done_later", drain_done, 0);
    idle_low(2);
    start_pass();
    run_drain(-1, 0, 1'b0, cyc);
    check("restart_cycles", cyc, NBT);
    idle_low(2);

    // Async reset between edges while beat 2 is presented.
    start_pass();
    e = exp_q.pop_front();
    check("rstmid_beat0", m_data, e.data);
    @(negedge clk);
    e = exp_q.pop_front();
    check("rstmid_beat1", m_data, e.data);
    @(negedge clk);
    m_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid", m_valid, 0);
    check("arst_busy", drain_busy, 0);
    check("arst_data", m_data, 0);
    check("arst_last", m_last, 0);
    check("arst_hdr", m_hdr, 0);
    check("arst_done", drain_done, 0);
    check("arst_err_cleared", err_overrun, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    m_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("held_done_no_start", m_valid, 0);
    end
    idle_low(2);
    start_pass();
    run_drain(-1, 0, 1'b0, cyc);
    check("post_reset_cycles", cyc, NBT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Reads the accumulated result matrix out of the systolic array after a compute pass and streams it row-major as LANES-element beats on a valid/ready interface.
- Sits between the array's `output_matrix`/`compute_done` outputs and the downstream writeback/DMA.
- Asserts `drain_busy` while streaming; the array controller must hold array `en` low while it is high, so the accumulators stay stable without a snapshot copy.

Parameters:
- ROWS, 64, array rows
- COLS, 64, array columns
- OP_WIDTH, 48, bits per result element
- LANES, 8, elements per output beat; must divide COLS (elaboration-time assertion)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- compute_done  input  1  array done level; high from pass end until next array en
- cycles_count  input  32  array cycle counter, valid with compute_done
- output_matrix  input  ROWS*COLS*OP_WIDTH  element (i,j) at bits [(i*COLS+j)*OP_WIDTH +: OP_WIDTH]
- flush  input  1  synchronous abort of an in-progress drain
- drain_busy  output  1  high from drain start until the last beat is accepted
- m_valid  output  1  beat valid
- m_ready  input  1  downstream accept
- m_data  output  LANES*OP_WIDTH  lane k at bits [k*OP_WIDTH +: OP_WIDTH]
- m_hdr  output  1  current beat is the header beat
- m_last  output  1  final beat of the matrix
- drain_done  output  1  one-cycle pulse after the last beat is accepted
- err_overrun  output  1  sticky: a new done edge arrived while busy

Behaviour:
- Reset (rst low, async): state IDLE; m_valid, m_hdr, m_last, drain_busy, drain_done, err_overrun = 0; m_data = 0; done_q = 0; beat counter = 0.
- Start: done edge = compute_done & ~done_q (done_q registered). A done edge in IDLE starts a drain:
  - next edge loads beat 0 into m_data and sets m_valid=1 and drain_busy=1.
  - Latency: m_valid is high in the cycle after compute_done is first sampled high.
- Beat order: NBEATS = ROWS*COLS/LANES; beat b covers row b/(COLS/LANES), columns (b%(COLS/LANES))*LANES + k.
- States:
  - IDLE -> STREAM on done edge.
  - STREAM: a handshake is m_valid & m_ready. On a handshake, load beat b+1, or on the last beat go to DONE.
  - DONE: drain_done=1 for exactly one cycle; drain_busy=0; m_valid=0; return to IDLE.
- Handshake rules:
  - m_data, m_hdr and m_last are registered and held stable while m_valid & ~m_ready.
  - m_valid never drops without a handshake, except on flush or reset.
  - Back-to-back handshakes give one beat per cycle.
- m_last=1 only on beat NBEATS-1.
- Overrun: a done edge while state != IDLE sets err_overrun (cleared only by reset); the current drain continues unaffected.
- flush:
  - In STREAM: next edge goes to IDLE with m_valid=0, drain_busy=0, no drain_done pulse.
  - flush has priority over a simultaneous handshake.
  - flush in IDLE has no effect.
  - A done edge in the same cycle as flush in IDLE still starts a drain.
- Level-high compute_done after a completed drain does not retrigger; a new pass requires compute_done to fall and rise again.
- Reset mid-drain: all outputs return to reset values immediately; the partial stream is abandoned.

Optional Feature:
- Macro: RESULT_DRAIN_HDR_EN.
- Defined: the first beat of every drain is a header beat, with m_hdr=1, m_data[31:0]=cycles_count captured at the done edge, upper bits 0, m_last=0. Matrix beats follow; total NBEATS+1 beats.
- Undefined: no header; m_hdr tied 0; beat 0 is matrix data.

Test Plan (ROWS=2, COLS=4, LANES=2, OP_WIDTH=48, element (i,j) = 16*i+j, header macro undefined):
- Full drain, m_ready=1 → edge on compute_done at cycle 10 gives m_valid at cycle 11. Beats at cycles 11-14: (0,1),(2,3),(16,17),(18,19); m_last on cycle 14; drain_done pulse cycle 15; drain_busy high cycles 11-14.
- Backpressure: m_ready low for 3 cycles on beat 1 → m_data holds {3,2} stable with m_valid high; stream resumes with no beat lost or duplicated.
- Overrun: pulse compute_done low then high during beat 2 → err_overrun=1 and stays 1; the 4 beats are still delivered correctly.
- Flush during beat 1 with m_ready=1 → next cycle m_valid=0, drain_busy=0, no drain_done. A later done edge restarts from beat 0.
- Async reset asserted mid-beat 2, between clock edges → all outputs 0 immediately. Holding compute_done high after release does not trigger a drain until it falls and rises.
- Header macro defined, cycles_count=0x0000_01F4 → 5 beats: beat 0 has m_hdr=1 and m_data=0x1F4, then the matrix beats as above; m_last on beat 4.
